// File: rtl/urv_defs.sv
// Shared uRV decode definitions: RV32I opcode/funct constants, immediate formats
// and the helper that tells whether an instruction reads rs1.
package urv_defs;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [2:0] FUN3_CSRRW = 3'b001;
  localparam logic [2:0] FUN3_CSRRS = 3'b010;
  localparam logic [2:0] FUN3_CSRRC = 3'b011;

  localparam logic [6:0] FUN7_BASE   = 7'b0000000;
  localparam logic [6:0] FUN7_ALT    = 7'b0100000;
  localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  // SYSTEM only reads rs1 for the register forms of the CSR instructions.
  function automatic logic uses_rs1(input logic [4:0] opc, input logic [2:0] fun3);
    case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: uses_rs1 = 1'b1;
      OPC_SYSTEM: uses_rs1 = (fun3 == FUN3_CSRRW) || (fun3 == FUN3_CSRRS) || (fun3 == FUN3_CSRRC);
      default:    uses_rs1 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/urv_decode_imm.sv
// Combinational immediate extractor: instruction word -> {format, sign-extended imm}.
// Encodings whose low bits are not 2'b11 are not 32-bit instructions and carry no immediate.
module urv_decode_imm
  import urv_defs::*;
(
  input  logic [31:0] ir_i,
  output logic [2:0]  fmt_o,
  output logic [31:0] imm_o
);

  imm_fmt_t fmt;

  always_comb begin
    fmt = FMT_NONE;
    if (ir_i[1:0] == 2'b11) begin
      case (ir_i[6:2])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
        OPC_STORE:                                  fmt = FMT_S;
        OPC_BRANCH:                                 fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
        OPC_JAL:                                    fmt = FMT_J;
        default:                                    fmt = FMT_NONE;
      endcase
    end
  end

  always_comb begin
    case (fmt)
      FMT_I:   imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
      FMT_S:   imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      FMT_B:   imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      FMT_U:   imm_o = {ir_i[31:12], 12'b0};
      FMT_J:   imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

  assign fmt_o = fmt;

endmodule

// File: rtl/urv_decode.sv
// uRV decode stage: registers the fetched instruction, extracts fields/immediate,
// inserts a load-use bubble. Optional illegal-opcode check under URV_ILLEGAL_INSN_CHECK_EN.
module urv_decode
  import urv_defs::*;
#(
  parameter int g_with_hw_mul         = 0,
  parameter int g_with_load_interlock = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  output logic        f_stall_o,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        d_valid_o,
  output logic [31:0] d_pc_o,
  output logic [4:0]  d_opcode_o,
  output logic [2:0]  d_fun_o,
  output logic [6:0]  d_fun7_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [4:0]  d_rd_o,
  output logic [31:0] d_imm_o,
  output logic        d_is_load_o,
  output logic        d_is_store_o,
  output logic        d_is_branch_o,
  output logic        d_illegal_o,
  output logic        d_load_hazard_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

  state_t      state_q;
  logic        d_valid_q, d_is_load_q, d_is_store_q, d_is_branch_q, d_illegal_q;
  logic [31:0] d_pc_q, d_imm_q;
  logic [4:0]  d_opcode_q, d_rs1_q, d_rs2_q, d_rd_q;
  logic [2:0]  d_fun_q;
  logic [6:0]  d_fun7_q;

  logic        f_rv32, f_is_load, f_is_store, f_is_branch, f_use_rs1, f_use_rs2, f_illegal;
  logic [4:0]  f_opc, f_rd;
  logic [2:0]  f_fmt;
  logic [31:0] f_imm;
  logic        hazard;

  urv_decode_imm u_imm (
    .ir_i  (f_ir_i),
    .fmt_o (f_fmt),
    .imm_o (f_imm)
  );

  // Non-32-bit encodings decode as "nothing": no class, no source, no immediate.
  assign f_rv32      = (f_ir_i[1:0] == 2'b11);
  assign f_opc       = f_ir_i[6:2];
  assign f_is_load   = f_rv32 && (f_opc == OPC_LOAD);
  assign f_is_store  = (f_fmt == FMT_S);
  assign f_is_branch = (f_fmt == FMT_B);
  assign f_use_rs1   = f_rv32 && uses_rs1(f_opc, f_ir_i[14:12]);
  assign f_use_rs2   = f_is_store || f_is_branch || (f_rv32 && (f_opc == OPC_OP));
  assign f_rd        = (f_is_store || f_is_branch) ? 5'd0 : f_ir_i[11:7];

  assign rf_rs1_o = f_ir_i[19:15];
  assign rf_rs2_o = f_ir_i[24:20];

`ifdef URV_ILLEGAL_INSN_CHECK_EN
  always_comb begin
    f_illegal = 1'b1;
    if (f_rv32) begin
      case (f_opc)
        OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP_IMM,
        OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_FENCE: f_illegal = 1'b0;
        OPC_OP: f_illegal = !((f_ir_i[31:25] == FUN7_BASE) || (f_ir_i[31:25] == FUN7_ALT) ||
                              ((g_with_hw_mul != 0) && (f_ir_i[31:25] == FUN7_MULDIV)));
        default: f_illegal = 1'b1;
      endcase
    end
  end
`else
  assign f_illegal = 1'b0;
`endif

  generate
    if (g_with_load_interlock != 0) begin : g_interlock
      assign hazard = (state_q == ST_RUN) && d_valid_q && d_is_load_q && (d_rd_q != 5'd0) &&
                      f_valid_i && !x_stall_i && !x_kill_i &&
                      ((f_use_rs1 && (f_ir_i[19:15] == d_rd_q)) ||
                       (f_use_rs2 && (f_ir_i[24:20] == d_rd_q)));
    end else begin : g_no_interlock
      assign hazard = 1'b0;
    end
  endgenerate

  assign d_load_hazard_o = hazard;
  assign f_stall_o       = rst_n_i && (x_stall_i || hazard);

  // Kill beats stall; a detected hazard drops D and holds fetch for exactly one edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_RUN;
      d_valid_q     <= 1'b0;
      d_pc_q        <= '0;
      d_opcode_q    <= '0;
      d_fun_q       <= '0;
      d_fun7_q      <= '0;
      d_rs1_q       <= '0;
      d_rs2_q       <= '0;
      d_rd_q        <= '0;
      d_imm_q       <= '0;
      d_is_load_q   <= 1'b0;
      d_is_store_q  <= 1'b0;
      d_is_branch_q <= 1'b0;
      d_illegal_q   <= 1'b0;
    end else if (x_kill_i) begin
      d_valid_q <= 1'b0;
      state_q   <= ST_RUN;
    end else if (!x_stall_i) begin
      if (hazard) begin
        d_valid_q <= 1'b0;
        state_q   <= ST_BUBBLE;
      end else begin
        state_q       <= ST_RUN;
        d_valid_q     <= f_valid_i;
        d_pc_q        <= f_pc_i;
        d_opcode_q    <= f_opc;
        d_fun_q       <= f_ir_i[14:12];
        d_fun7_q      <= f_ir_i[31:25];
        d_rs1_q       <= f_use_rs1 ? f_ir_i[19:15] : 5'd0;
        d_rs2_q       <= f_use_rs2 ? f_ir_i[24:20] : 5'd0;
        d_rd_q        <= f_rd;
        d_imm_q       <= f_imm;
        d_is_load_q   <= f_is_load;
        d_is_store_q  <= f_is_store;
        d_is_branch_q <= f_is_branch;
        d_illegal_q   <= f_illegal;
      end
    end
  end

  assign d_valid_o     = d_valid_q;
  assign d_pc_o        = d_pc_q;
  assign d_opcode_o    = d_opcode_q;
  assign d_fun_o       = d_fun_q;
  assign d_fun7_o      = d_fun7_q;
  assign d_rs1_o       = d_rs1_q;
  assign d_rs2_o       = d_rs2_q;
  assign d_rd_o        = d_rd_q;
  assign d_imm_o       = d_imm_q;
  assign d_is_load_o   = d_is_load_q;
  assign d_is_store_o  = d_is_store_q;
  assign d_is_branch_o = d_is_branch_q;
  assign d_illegal_o   = d_illegal_q;

endmodule

// File: tb/tb_urv_decode.sv
// Bench for urv_decode: directed cases then constrained-random traffic against a
// table-driven RV32I reference model of the decode stage.
module tb_urv_decode;

  localparam bit HW_MUL = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n_i, f_valid_i, x_stall_i, x_kill_i;
  logic [31:0] f_ir_i, f_pc_i;
  logic        f_stall_o, d_valid_o, d_is_load_o, d_is_store_o, d_is_branch_o;
  logic        d_illegal_o, d_load_hazard_o;
  logic [4:0]  rf_rs1_o, rf_rs2_o, d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
  logic [2:0]  d_fun_o;
  logic [6:0]  d_fun7_o;
  logic [31:0] d_pc_o, d_imm_o;

  always #5 clk = ~clk;

  urv_decode #(.g_with_hw_mul(0), .g_with_load_interlock(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .f_valid_i(f_valid_i), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i),
    .f_stall_o(f_stall_o), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .d_valid_o(d_valid_o), .d_pc_o(d_pc_o),
    .d_opcode_o(d_opcode_o), .d_fun_o(d_fun_o), .d_fun7_o(d_fun7_o), .d_rs1_o(d_rs1_o),
    .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o), .d_imm_o(d_imm_o), .d_is_load_o(d_is_load_o),
    .d_is_store_o(d_is_store_o), .d_is_branch_o(d_is_branch_o), .d_illegal_o(d_illegal_o),
    .d_load_hazard_o(d_load_hazard_o)
  );

  typedef enum {K_NONE, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_OP, K_OPIMM,
                K_LUI, K_AUIPC, K_SYSTEM, K_FENCE} kind_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  opc;
    logic [2:0]  fun;
    logic [6:0]  fun7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ld, st, br, ill;
  } dstage_t;

  dstage_t m;
  bit      m_bubble;
  int      n_checks = 0, n_fail = 0, n_step = 0;
  logic    obs_stall, obs_haz;

  function automatic kind_e kind_of(input logic [6:0] op7);
    case (op7)
      7'h03: return K_LOAD;    7'h23: return K_STORE;  7'h63: return K_BRANCH;
      7'h6F: return K_JAL;     7'h67: return K_JALR;   7'h33: return K_OP;
      7'h13: return K_OPIMM;   7'h37: return K_LUI;    7'h17: return K_AUIPC;
      7'h73: return K_SYSTEM;  7'h0F: return K_FENCE;
      default: return K_NONE;
    endcase
  endfunction

  function automatic dstage_t ref_decode(input bit v, input logic [31:0] ir, input logic [31:0] pc);
    dstage_t r;
    kind_e   k;
    int      imm;
    logic [6:0] f7;
    r = '0;
    k = kind_of(ir[6:0]);
    f7 = ir[31:25];
    r.valid = v; r.pc = pc; r.opc = ir[6:2]; r.fun = ir[14:12]; r.fun7 = f7;
    imm = 0;
    case (k)
      K_LOAD, K_OPIMM, K_JALR, K_SYSTEM: imm = $signed(ir[31:20]);
      K_STORE:         imm = $signed({ir[31:25], ir[11:7]});
      K_BRANCH:        imm = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      K_LUI, K_AUIPC:  imm = int'({ir[31:12], 12'h000});
      K_JAL:           imm = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      default:         imm = 0;
    endcase
    r.imm = imm;
    if (k inside {K_JALR, K_BRANCH, K_LOAD, K_STORE, K_OPIMM, K_OP} ||
        (k == K_SYSTEM && ir[14:12] inside {3'd1, 3'd2, 3'd3}))
      r.rs1 = ir[19:15];
    if (k inside {K_BRANCH, K_STORE, K_OP}) r.rs2 = ir[24:20];
    r.rd = (k == K_BRANCH || k == K_STORE) ? 5'd0 : ir[11:7];
    r.ld = (k == K_LOAD);
    r.st = (k == K_STORE);
    r.br = (k == K_BRANCH);
`ifdef URV_ILLEGAL_INSN_CHECK_EN
    r.ill = (k == K_NONE) || (k == K_OP && !(f7 == 7'd0 || f7 == 7'd32 || (HW_MUL && f7 == 7'd1)));
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_d();
    chk("d_valid", d_valid_o, m.valid);
    if (m.valid) begin
      chk("d_pc", d_pc_o, m.pc);           chk("d_opcode", d_opcode_o, m.opc);
      chk("d_fun", d_fun_o, m.fun);        chk("d_fun7", d_fun7_o, m.fun7);
      chk("d_rs1", d_rs1_o, m.rs1);        chk("d_rs2", d_rs2_o, m.rs2);
      chk("d_rd", d_rd_o, m.rd);           chk("d_imm", d_imm_o, m.imm);
      chk("d_is_load", d_is_load_o, m.ld); chk("d_is_store", d_is_store_o, m.st);
      chk("d_is_branch", d_is_branch_o, m.br);
      chk("d_illegal", d_illegal_o, m.ill);
    end
  endtask

  // One clock of traffic: entered and left 1 time unit after a rising edge.
  task automatic step(input bit fv, input logic [31:0] ir, input logic [31:0] pc,
                      input bit xs, input bit xk);
    dstage_t dec;
    bit      haz;
    f_valid_i = fv; f_ir_i = ir; f_pc_i = pc; x_stall_i = xs; x_kill_i = xk;
    #1;
    dec = ref_decode(fv, ir, pc);
    haz = !m_bubble && m.valid && m.ld && (m.rd != 5'd0) && fv && !xs && !xk &&
          ((dec.rs1 == m.rd) || (dec.rs2 == m.rd));
    obs_stall = f_stall_o;
    obs_haz   = d_load_hazard_o;
    chk("f_stall", f_stall_o, xs || haz);
    chk("load_hazard", d_load_hazard_o, haz);
    chk("rf_rs1", rf_rs1_o, ir[19:15]);
    chk("rf_rs2", rf_rs2_o, ir[24:20]);
    @(posedge clk);
    if (xk) begin
      m.valid = 1'b0; m_bubble = 1'b0;
    end else if (!xs) begin
      if (haz) begin
        m.valid = 1'b0; m_bubble = 1'b1;
      end else begin
        m = dec; m_bubble = 1'b0;
      end
    end
    #1;
    check_d();
    n_step++;
    $display("step %0d fv=%0b ir=%08h pc=%08h xs=%0b xk=%0b haz=%0b -> d_valid=%0b rd=%0d imm=%08h",
             n_step, fv, ir, pc, xs, xk, haz, d_valid_o, d_rd_o, d_imm_o);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] ir;
    logic [6:0]  ops [12];
    logic [6:0]  f7s [4];
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h0B};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h55};
    ir = $urandom;
    ir[6:0]   = ops[$urandom_range(0, 11)];
    ir[11:7]  = 5'($urandom_range(0, 7));
    ir[19:15] = 5'($urandom_range(0, 7));
    ir[24:20] = 5'($urandom_range(0, 7));
    if (ir[6:0] == 7'h33) ir[31:25] = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 15) == 0) ir[1:0] = 2'($urandom_range(0, 2));
    return ir;
  endfunction

  initial begin
    rst_n_i = 1'b0; f_valid_i = 1'b1; f_ir_i = 32'h0000A283; f_pc_i = 32'h40;
    x_stall_i = 1'b1; x_kill_i = 1'b0;
    m = '0; m_bubble = 1'b0;
    #2;
    chk("rst_d_valid", d_valid_o, 0);   chk("rst_d_pc", d_pc_o, 0);
    chk("rst_d_imm", d_imm_o, 0);       chk("rst_d_rd", d_rd_o, 0);
    chk("rst_d_is_load", d_is_load_o, 0);
    chk("rst_f_stall", f_stall_o, 0);
    #8 rst_n_i = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hold", d_valid_o, 0);

    step(1, 32'hFFF00093, 32'h100, 0, 0);
    chk("addi_pc", d_pc_o, 32'h100); chk("addi_rd", d_rd_o, 1); chk("addi_imm", d_imm_o, 32'hFFFFFFFF);
    step(1, 32'h00208463, 32'h104, 0, 0);
    chk("beq_imm", d_imm_o, 32'h8); chk("beq_rd", d_rd_o, 0); chk("beq_br", d_is_branch_o, 1);
    step(1, 32'h0000006F, 32'h108, 0, 0);
    chk("jal_imm", d_imm_o, 0);

    // LW x5 then ADD x6,x5,x7: one bubble, then ADD enters D
    step(1, 32'h0000A283, 32'h10C, 0, 0);
    step(1, 32'h00728333, 32'h110, 0, 0);
    chk("lu_stall", obs_stall, 1); chk("lu_haz", obs_haz, 1); chk("lu_bubble_valid", d_valid_o, 0);
    step(1, 32'h00728333, 32'h110, 0, 0);
    chk("lu_after_haz", obs_haz, 0); chk("lu_add_valid", d_valid_o, 1); chk("lu_add_rd", d_rd_o, 6);

    // LW x0 then ADD reading x0: no bubble
    step(1, 32'h0000A003, 32'h114, 0, 0);
    step(1, 32'h00700333, 32'h118, 0, 0);
    chk("x0_no_haz", obs_haz, 0); chk("x0_add_pc", d_pc_o, 32'h118);

    for (int i = 0; i < 3; i++) begin
      step(1, rand_insn(), $urandom, 1, 0);
      chk("stall_pc_held", d_pc_o, 32'h118);
    end
    step(1, rand_insn(), 32'h200, 1, 1);
    chk("kill_over_stall", d_valid_o, 0);

    // kill while in the bubble returns to normal flow
    step(1, 32'h0000A283, 32'h120, 0, 0);
    step(1, 32'h00728333, 32'h124, 0, 0);
    step(1, 32'h00728333, 32'h124, 0, 1);
    step(1, 32'h00728333, 32'h124, 0, 0);
    chk("post_kill_capture", d_pc_o, 32'h124);

    // asynchronous reset in mid-stream
    x_stall_i = 1'b1;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", d_valid_o, 0); chk("mid_rst_pc", d_pc_o, 0);
    chk("mid_rst_imm", d_imm_o, 0);     chk("mid_rst_stall", f_stall_o, 0);
    m = '0; m_bubble = 1'b0;
    #3 rst_n_i = 1'b1;
    @(posedge clk); #1;

`ifdef URV_ILLEGAL_INSN_CHECK_EN
    step(1, 32'h00000000, 32'h300, 0, 0);
    chk("ill_zero", d_illegal_o, 1);
    step(1, 32'h02728333, 32'h304, 0, 0);
    chk("ill_mul", d_illegal_o, !HW_MUL);
    step(1, 32'h40728333, 32'h308, 0, 0);
    chk("ill_sub", d_illegal_o, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) != 0, rand_insn(), $urandom,
           $urandom_range(0, 6) == 0, $urandom_range(0, 12) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
